// File: rtl/oam_dma_ctrl_pkg.sv
// oam_dma_ctrl_pkg: shared DMA state type and bus address constants
package oam_dma_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA sequencer copying a 256-byte page to the OAM data port
module oam_dma_ctrl #(
  parameter logic [15:0] OAMDMA_ADDR = oam_dma_ctrl_pkg::OAMDMA_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = oam_dma_ctrl_pkg::OAMDATA_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_r_en,
  input  logic [7:0]  mem_r_data,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_w_data,
  output logic        dma_r_en,
  output logic        bus_grant,
  output logic        cpu_halt
);
  import oam_dma_ctrl_pkg::*;
  dma_state_t state, state_nxt;
  logic [7:0] page, index;
  logic parity, trigger;
  assign trigger = cpu_addr == OAMDMA_ADDR && !cpu_r_en;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      page <= '0;
      index <= '0;
      parity <= 1'b0;
    end else if (clock_en) begin
      state <= state_nxt;
      parity <= ~parity;
      if (state == IDLE && trigger) begin
        page <= cpu_w_data;
        index <= 8'h00;
      end
      if (state == WRITE) index <= index + 8'd1;
    end
  always_comb begin
    state_nxt = state == IDLE  ? (trigger ? HALT : IDLE) :
                state == HALT  ? (parity ? READ : ALIGN) :
                state == ALIGN ? READ :
                state == READ  ? WRITE :
                index == 8'hFF ? IDLE : READ;
    bus_grant = state != IDLE;
    cpu_halt = state != IDLE;
    dma_r_en = state != WRITE;
    dma_addr = state == IDLE  ? 16'h0000 :
               state == WRITE ? OAMDATA_ADDR :
               state == READ  ? {page, index} : {page, 8'h00};
    dma_w_data = state == WRITE ? mem_r_data : 8'h00;
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: randomized directed bench for oam_dma_ctrl against a transfer-level model
module tb_oam_dma_ctrl;
  logic clock = 1'b0, reset = 1'b1, clock_en = 1'b0, cpu_r_en = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_w_data = '0;
  logic [7:0] mem_r_data;
  logic [15:0] dma_addr;
  logic [7:0] dma_w_data;
  logic dma_r_en, bus_grant, cpu_halt;
  typedef struct packed {logic par; logic r; logic [15:0] a; logic [7:0] d;} ev_t;
  ev_t log_q[$];
  logic [7:0] mem [65536];
  int checks = 0, errors = 0, ce_count = 0, grant_clk = 0, hold_bad = 0;
  logic prev_ce = 1'b1, prev_rst = 1'b1;
  logic [27:0] prev_out = '0;
  oam_dma_ctrl dut (
    .clock(clock), .reset(reset), .clock_en(clock_en), .cpu_addr(cpu_addr),
    .cpu_w_data(cpu_w_data), .cpu_r_en(cpu_r_en), .mem_r_data(mem_r_data),
    .dma_addr(dma_addr), .dma_w_data(dma_w_data), .dma_r_en(dma_r_en),
    .bus_grant(bus_grant), .cpu_halt(cpu_halt)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (clock_en) mem_r_data <= mem[bus_grant ? dma_addr : cpu_addr];
  always @(negedge clock) begin
    if (bus_grant) grant_clk++;
    if (!prev_ce && !prev_rst && {dma_addr, dma_w_data, dma_r_en, bus_grant, cpu_halt} !== prev_out) hold_bad++;
    prev_out = {dma_addr, dma_w_data, dma_r_en, bus_grant, cpu_halt};
    prev_ce = clock_en;
    prev_rst = reset;
    if (clock_en && bus_grant) log_q.push_back('{ce_count[0], dma_r_en, dma_addr, dma_w_data});
    if (reset) ce_count = 0;
    else if (clock_en) ce_count++;
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, {31'b0, bus_grant}, 0);
    chk({tag, "_halt"}, {31'b0, cpu_halt}, 0);
    chk({tag, "_addr"}, {16'b0, dma_addr}, 0);
    chk({tag, "_wdata"}, {24'b0, dma_w_data}, 0);
    chk({tag, "_ren"}, {31'b0, dma_r_en}, 1);
  endtask
  task automatic trigger(input logic [7:0] pg);
    clock_en = 1'b1;
    {cpu_addr, cpu_r_en, cpu_w_data} = {16'h4014, 1'b0, pg};
    step();
    {cpu_addr, cpu_r_en, cpu_w_data} = {16'h0000, 1'b1, 8'h00};
  endtask
  // hp is the parity of the first HALT cycle; the first READ must then land on even parity
  task automatic run_transfer(input logic [7:0] pg, input logic hp, input int div, input bit poke);
    int nd, len;
    logic [15:0] ad;
    clock_en = 1'b1;
    {cpu_addr, cpu_r_en, cpu_w_data} = {16'h0000, 1'b1, 8'h00};
    if (ce_count[0] == hp) step();
    log_q.delete();
    grant_clk = 0;
    hold_bad = 0;
    trigger(pg);
    for (int k = 1; k < 6000; k++) begin
      clock_en = (k % div == 0);
      {cpu_addr, cpu_r_en, cpu_w_data} = (poke && k == 100 * div) ? {16'h4014, 1'b0, ~pg} : {16'h0000, 1'b1, 8'h00};
      step();
      if (!bus_grant) break;
    end
    clock_en = 1'b1;
    {cpu_addr, cpu_r_en, cpu_w_data} = {16'h0000, 1'b1, 8'h00};
    chk("xfer_done", {31'b0, bus_grant}, 0);
    nd = hp ? 1 : 2;
    len = nd + 512;
    chk("xfer_len", log_q.size(), len);
    chk("grant_clocks", grant_clk, len * div);
    if (div > 1) chk("hold_stable", hold_bad, 0);
    for (int i = 0; i < nd && i < log_q.size(); i++)
      chk("dummy_rd", {15'b0, log_q[i].r, log_q[i].a}, {15'b0, 1'b1, pg, 8'h00});
    if (log_q.size() > nd) chk("first_read_par", {31'b0, log_q[nd].par}, 0);
    for (int n = 0; n < 256; n++) begin
      ad = {pg, n[7:0]};
      if (nd + 2 * n + 1 < log_q.size()) begin
        chk("rd", {15'b0, log_q[nd + 2 * n].r, log_q[nd + 2 * n].a}, {15'b0, 1'b1, ad});
        chk("wr", {7'b0, log_q[nd + 2 * n + 1].r, log_q[nd + 2 * n + 1].a, log_q[nd + 2 * n + 1].d},
            {7'b0, 1'b0, 16'h2004, mem[ad]});
      end
    end
    chk_idle("post_xfer");
  endtask
  initial begin
    logic [7:0] pg;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
    clock_en = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk_idle("reset");
    clock_en = 1'b1;
    {cpu_addr, cpu_r_en} = {16'h4014, 1'b1};
    repeat (5) step();
    chk("read_no_trig", {31'b0, bus_grant}, 0);
    clock_en = 1'b0;
    {cpu_addr, cpu_r_en} = {16'h4014, 1'b0};
    repeat (3) step();
    chk("ce0_no_trig", {31'b0, bus_grant}, 0);
    {cpu_addr, cpu_r_en} = {16'h0000, 1'b1};
    run_transfer(8'h02, 1'b0, 1, 0);
    run_transfer(8'h02, 1'b1, 1, 0);
    run_transfer(8'h03, 1'($urandom), 1, 0);
    run_transfer(8'($urandom), 1'($urandom), 3, 0);
    run_transfer(8'($urandom), 1'($urandom), 1, 1);
    repeat ($urandom_range(1, 4)) step();
    trigger(8'h03);
    for (int k = 0; k < 2000 && dma_addr != 16'h0340; k++) step();
    chk("at_read_40", {16'b0, dma_addr}, 32'h0340);
    step();
    chk("at_write_40", {16'b0, dma_addr}, 32'h2004);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("mid_reset");
    log_q.delete();
    repeat (20) step();
    chk("no_write_after_reset", log_q.size(), 0);
    pg = 8'($urandom);
    run_transfer(8'h03, 1'($urandom), 1, 0);
    run_transfer(pg, 1'($urandom), 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter OAMDMA_ADDR, default 16'h4014, meaning the CPU write address that triggers DMA.
REQ-002 SHALL have parameter OAMDATA_ADDR, default 16'h2004, meaning the PPU OAM data port that DMA writes target.
REQ-003 SHALL have port: clock  input  1  system clock; one clock, all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: clock_en  input  1  CPU cycle enable; state advances only when high.
REQ-006 SHALL have port: cpu_addr  input  16  CPU-driven bus address.
REQ-007 SHALL have port: cpu_w_data  input  8  CPU-driven write data.
REQ-008 SHALL have port: cpu_r_en  input  1  CPU read enable; 1 = read, 0 = write.
REQ-009 SHALL have port: mem_r_data  input  8  memory read data, registered, valid the clock_en cycle after address.
REQ-010 SHALL have port: dma_addr  output  16  DMA-driven bus address.
REQ-011 SHALL have port: dma_w_data  output  8  DMA-driven write data.
REQ-012 SHALL have port: dma_r_en  output  1  DMA read enable; 1 = read, 0 = write.
REQ-013 SHALL have port: bus_grant  output  1  1 = memory bus muxed to dma_* signals, 0 = muxed to cpu_*.
REQ-014 SHALL have port: cpu_halt  output  1  stalls CPU microcode sequencing while high.

Function
REQ-015 States SHALL be IDLE, HALT, ALIGN, READ, WRITE; all transitions occur only on clock with clock_en=1.
REQ-016 Parity bit SHALL toggle every clock_en cycle; it is 0 on the cycle after reset.
REQ-017 IDLE->HALT SHALL occur when cpu_addr==OAMDMA_ADDR, cpu_r_en==0 and clock_en==1; page register latches cpu_w_data and index resets to 8'h00.
REQ-018 HALT SHALL last one cycle, then go to READ if parity==1 (next cycle even), else to ALIGN.
REQ-019 ALIGN SHALL last one cycle, then go to READ.
REQ-020 READ SHALL drive dma_addr={page,index}, dma_r_en=1, then go to WRITE.
REQ-021 WRITE SHALL drive dma_addr=OAMDATA_ADDR, dma_r_en=0, dma_w_data=mem_r_data.
REQ-022 WRITE SHALL increment index mod 256, then go to READ, or to IDLE if index was 8'hFF.
REQ-023 In HALT/ALIGN SHALL drive dma_addr={page,8'h00}, dma_r_en=1 (dummy read, no side effect).
REQ-024 bus_grant and cpu_halt SHALL be 1 in HALT, ALIGN, READ and WRITE, and 0 in IDLE.
REQ-025 Total transfer SHALL be 513 clock_en cycles (trigger on odd parity) or 514 (even), counted from the first HALT cycle to return to IDLE.
REQ-026 A write to OAMDMA_ADDR while not IDLE SHALL be ignored.
REQ-027 With clock_en=0, state, index, page and parity SHALL hold; outputs stay stable.
REQ-028 In IDLE, dma_addr=16'h0000, dma_w_data=8'h00, dma_r_en=1.
REQ-029 CPU reads of OAMDMA_ADDR SHALL NOT trigger DMA.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, page=8'h00, index=8'h00, parity=0, bus_grant=0, cpu_halt=0, dma_addr=16'h0000, dma_w_data=8'h00, dma_r_en=1, regardless of clock_en.
REQ-031 Reset mid-transfer SHALL abandon the transfer; no further DMA write is issued.

Structure
REQ-032 dma_state_t enum and the constants OAMDMA_ADDR and OAMDATA_ADDR SHALL live in the shared CPU package.
REQ-033 Single FSM module; no sub-modules; the bus mux stays outside in the CPU top level.

Verification
REQ-034 Write 8'h02 to 16'h4014 on even parity -> 514 cycles; dma_addr sequence is 0200, 2004, 0201 ... 02FF, 2004; 256 writes; then IDLE.
REQ-035 Same trigger on odd parity -> ALIGN skipped; 513 cycles; first READ on even parity.
REQ-036 Preload 16'h0300-16'h03FF with value=index^8'hA5 -> write n carries data 8'hA5^n.
REQ-037 clock_en duty 1-in-3 during transfer -> identical address/data sequence; cycle count scaled by 3.
REQ-038 Assert reset at WRITE of index 8'h40 -> next cycle IDLE, bus_grant=0, cpu_halt=0; retrigger starts at index 8'h00.
REQ-039 Write 16'h4014 during a transfer, and read 16'h4014 from IDLE -> no restart, page unchanged, no trigger.
